// File: rtl/freq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_pkg
// Description : Shared sizing defaults and FSM state type for the binary to
//               BCD converter and the downstream rounding stage.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_pkg;

    // DIGITS must stay in step with the rounding stage that consumes BCD_out.
    localparam int c_BIN_W_DEFAULT  = 20;
    localparam int c_DIGITS_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage : freq_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Double-dabble correction for one BCD digit (add 3 if >= 5).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential binary to packed-BCD converter, one bit per cycle.
//               Define BIN2BCD_SAT_EN to saturate BCD_out to all nines on
//               overflow; otherwise the result is truncated modulo 10^DIGITS.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import freq_pkg::*;
#(
    parameter int BIN_W  = c_BIN_W_DEFAULT,
    parameter int DIGITS = c_DIGITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   BCD_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
`ifdef BIN2BCD_SAT_EN
    localparam logic [BCD_W-1:0] c_ALL_NINES = {DIGITS{4'h9}};
`endif

    state_t             r_state;
    logic [BIN_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [BCD_W-1:0]   w_adj;

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            bcd_digit_adj u_adj (
                .digit_in  (r_bcd[4*d +: 4]),
                .digit_out (w_adj[4*d +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            BCD_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The done cycle is also IDLE; a start there is dropped.
                    if (start && !done) begin
                        r_bin   <= bin_in;
                        r_bcd   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= CNT_W'(BIN_W);
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
                    if (w_adj[BCD_W-1]) begin
                        r_ovf <= 1'b1;
                    end
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
`ifdef BIN2BCD_SAT_EN
                    BCD_out <= r_ovf ? c_ALL_NINES : r_bcd;
`else
                    BCD_out <= r_bcd;
`endif
                    overflow <= r_ovf;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : bin2bcd_seq
`default_nettype wire
